// File: rtl/spi_reg_writer_pkg.sv
// Shared types and constants for the SPI register writer: FSM states, register
// addresses and frame geometry.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;

    localparam int         FRAME_BITS = 16;
    localparam logic [4:0] CNT_FULL   = 5'(FRAME_BITS);
    // One past a full frame; the counter parks here so over-long frames stay invalid.
    localparam logic [4:0] CNT_SAT    = 5'(FRAME_BITS + 1);

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a history flop that
// turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_VAL}};
            hist_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 peripheral that commits 16-bit write frames into five PWM control
// registers. Optional register readback on cipo is enabled by SPI_READBACK_EN.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done
);

    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic ncs_level, ncs_rise, ncs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d_i(copi),
        .level_o(copi_level), .rise_o(copi_rise), .fall_o(copi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d_i(ncs),
        .level_o(ncs_level), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        frame_ok, commit;

    assign frame_ok = (bit_cnt_q == CNT_FULL) && shift_q[15] && (shift_q[14:8] <= MAX_A);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = DONE;
                end else if (sclk_rise && !ncs_level) begin
                    shift_d = {shift_q[14:0], copi_level};
                    if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            DONE: begin
                commit  = frame_ok;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            frame_done      <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            frame_done <= commit;
            if (commit) begin
                case (shift_q[14:8])
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_q[7:0];
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_q[7:0];
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_q[7:0];
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_q[7:0];
                    ADDR_DUTY:      pwm_duty_cycle  <= shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, rd_data;
    logic       cipo_q, rd_ok_q;
    logic       rd_load, rd_shift;

    // shift_d already holds the 8th bit here, so bits 7:0 are R/W and address.
    assign rd_load  = (state_q == SHIFT) && sclk_rise && !ncs_level && (bit_cnt_q == 5'd7);
    assign rd_shift = (state_q == SHIFT) && sclk_fall && !ncs_level &&
                      (bit_cnt_q >= 5'd8) && (bit_cnt_q < CNT_FULL);

    always_comb begin
        rd_data = '0;
        case (shift_d[6:0])
            ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
            ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
            ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
            ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
            ADDR_DUTY:      rd_data = pwm_duty_cycle;
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q    <= '0;
            cipo_q  <= 1'b0;
            rd_ok_q <= 1'b0;
        end else if (state_q == IDLE) begin
            cipo_q  <= 1'b0;
            rd_ok_q <= 1'b0;
        end else if (rd_load) begin
            tx_q    <= rd_data;
            rd_ok_q <= !shift_d[7] && (shift_d[6:0] <= MAX_A);
        end else if (rd_shift) begin
            cipo_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
        end
    end

    assign cipo = cipo_q & rd_ok_q & ~ncs_level;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: drives SPI frames at SCLK = clk/8 and
// checks register state, commit latency and frame_done pulses.
module tb_spi_reg_writer;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic       cipo, frame_done;
  logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         fd_cnt   = 0;
  logic [7:0] rx;

  always #5 clk = ~clk;

  spi_reg_writer dut (
    .clk            (clk),
    .rst            (rst),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .cipo           (cipo),
    .en_reg_out_7_0 (r_out_lo),
    .en_reg_out_15_8(r_out_hi),
    .en_reg_pwm_7_0 (r_pwm_lo),
    .en_reg_pwm_15_8(r_pwm_hi),
    .pwm_duty_cycle (r_duty),
    .frame_done     (frame_done)
  );

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                            input int efd);
    check({tag, ".out_lo"}, 32'(r_out_lo), 32'(e0));
    check({tag, ".out_hi"}, 32'(r_out_hi), 32'(e1));
    check({tag, ".pwm_lo"}, 32'(r_pwm_lo), 32'(e2));
    check({tag, ".pwm_hi"}, 32'(r_pwm_hi), 32'(e3));
    check({tag, ".duty"},   32'(r_duty),   32'(e4));
    check({tag, ".fd_cnt"}, 32'(fd_cnt),   32'(efd));
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Mode 0: data set while sclk low, sampled by the peripheral on the rise.
  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      copi = val[n-1-i];
      wait_neg(4);
      if (i >= 8 && i < 16) rx = {rx[6:0], cipo};
      sclk = 1'b1;
      wait_neg(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] val, input int n);
    ncs = 1'b0;
    wait_neg(4);
    shift_bits(val, n);
    wait_neg(4);
    ncs = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; rx = '0;
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    check("reset.cipo", 32'(cipo), 32'd0);
    check("reset.frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after 10 bits abandons the frame even if the remaining bits arrive.
    ncs = 1'b0;
    wait_neg(4);
    shift_bits(32'h0000_0213, 10);
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    shift_bits(32'h0000_003F, 6);
    wait_neg(4);
    ncs = 1'b1;
    settle();
    check_regs("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // Duty write: registers move on the 4th clk edge after ncs rises.
    wait_neg(1);
    frame(32'h8455, 16);
    repeat (3) @(posedge clk);
    #1;
    check("lat.edge3.duty", 32'(r_duty), 32'h00);
    check("lat.edge3.fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    check("lat.edge4.duty", 32'(r_duty), 32'h55);
    check("lat.edge4.fd", 32'(frame_done), 32'd1);
    @(posedge clk);
    #1;
    check("lat.edge5.fd", 32'(frame_done), 32'd0);
    settle();
    check_regs("duty", 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 1);

    // Back-to-back frames with 2 clk of ncs high.
    wait_neg(1);
    frame(32'h80F0, 16);
    wait_neg(2);
    frame(32'h810F, 16);
    settle();
    check_regs("b2b", 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h55, 3);

    wait_neg(1);
    frame(32'h4233, 15);
    settle();
    check_regs("short15", 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h55, 3);

    wait_neg(1);
    frame(32'h1_8477, 17);
    settle();
    check_regs("long17", 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h55, 3);

    wait_neg(1);
    frame(32'h85AA, 16);
    settle();
    check_regs("bad_addr", 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h55, 3);

    wait_neg(1);
    rx = '0;
    frame(32'h0200, 16);
    settle();
    check_regs("read02", 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h55, 3);
    check("idle.cipo", 32'(cipo), 32'd0);

    // sclk activity with ncs high must not shift anything.
    wait_neg(1);
    for (int k = 0; k < 8; k++) begin
      copi = 1'($urandom_range(1, 0));
      sclk = 1'b1;
      wait_neg(4);
      sclk = 1'b0;
      wait_neg(4);
    end
    frame(32'h8233, 16);
    settle();
    check_regs("sclk_hi", 8'hF0, 8'h0F, 8'h33, 8'h00, 8'h55, 4);

`ifdef SPI_READBACK_EN
    wait_neg(1);
    frame(32'h83C3, 16);
    settle();
    check_regs("wr03", 8'hF0, 8'h0F, 8'h33, 8'hC3, 8'h55, 5);
    wait_neg(1);
    rx = '0;
    frame(32'h0300, 16);
    settle();
    check("readback.rx", 32'(rx), 32'hC3);
    check_regs("rd03", 8'hF0, 8'h0F, 8'h33, 8'hC3, 8'h55, 5);
    check("readback.cipo_idle", 32'(cipo), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
